instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the multi-cycle RISC core: owns the PC and the instruction register (IR).
//  - Fetches 16-bit words from instruction memory over a req/ack handshake when the control FSM's IF state pulses pc_write.
//  - Supplies instruction/opcode to control_unit.
//  - Applies branch/jump redirects using the PC of the instruction currently in the IR.
// PARAMETERS
//  RESET_PC   16'h0000  PC value after reset (word address)
//  NOP_INSTR  16'hF000  IR value after reset and after a fetch timeout; opcode 4'hF has no decode path in control
//  MAX_WAIT   8         wait-state limit: cycles imem_req may stay high without imem_ack before timeout
// PORTS
//  clk          in   1   core clock, all state updates on posedge
//  proc_rst     in   1   synchronous, active-high reset
//  pc_write     in   1   fetch request from control (level, sampled each cycle)
//  branch       in   1   conditional branch request (BEQ, opcode 4'b1011)
//  jump         in   1   unconditional jump request (opcode 4'b1101)
//  Zero         in   1   ALU zero flag; qualifies branch
//  imem_req     out  1   instruction memory read request
//  imem_addr    out  16  instruction memory word address
//  imem_rdata   in   16  instruction memory read data, valid when imem_ack=1
//  imem_ack     in   1   read completion strobe
//  instruction  out  16  IR contents
//  opcode       out  4   instruction[15:12]
//  ir_valid     out  1   IR holds a freshly fetched (or timeout NOP) word
//  pc           out  16  next fetch address
//  pc_cur       out  16  address of the instruction in the IR
//  fetch_err    out  1   sticky flag: a fetch timed out
// BEHAVIOUR
//  Reset (proc_rst=1 at posedge) values:
//   pc=pc_cur=RESET_PC, instruction=NOP_INSTR, ir_valid=0, imem_req=0, fetch_err=0, wait_cnt=0.
//   FSM goes to IDLE; imem_addr follows pc.
//  FSM, two states:
//   IDLE: imem_req=0.
//    - If pc_write=1: ir_valid<=0, imem_addr<=fetch address, imem_req<=1, wait_cnt<=0, go to FETCH.
//   FETCH: imem_req=1; imem_addr is held stable for the whole request.
//    - imem_ack=1: instruction<=imem_rdata, pc_cur<=imem_addr, pc<=imem_addr+1, ir_valid<=1, imem_req<=0, go to IDLE.
//    - imem_ack=0 and wait_cnt==MAX_WAIT-1: instruction<=NOP_INSTR, ir_valid<=1, fetch_err<=1, pc unchanged, imem_req<=0, go to IDLE.
//    - Otherwise: wait_cnt++.
//  Latency: imem_req rises on the edge that samples pc_write. With zero-wait memory (ack in the first req cycle), IR is valid 2 edges after pc_write.
//  imem_ack while imem_req=0 is ignored. pc_write while in FETCH is ignored.
//  Redirect, evaluated only in IDLE:
//   - taken = jump | (branch & Zero).
//   - Branch target = pc_cur + sext(instruction[5:0]); jump target = pc_cur + sext(instruction[8:0]).
//   - jump takes priority if both are asserted.
//   - Taken: pc<=target. Holding the request level is idempotent because the target is computed from pc_cur.
//   - branch with Zero=0: no change.
//  Fetch address = taken ? target : pc. A redirect and pc_write in the same cycle fetch from target, and pc is also set to target.
//  Arithmetic: all PC math is 16-bit, modulo 2^16. 16'hFFFF+1 wraps to 16'h0000; negative offsets wrap below 0.
//  Reset mid-FETCH: imem_req=0 after that edge; an ack arriving in the same or later cycle is ignored.
//  fetch_err clears only on proc_rst.
//  opcode is combinational from instruction; every other output is registered.
// STRUCTURE
//  Shared package (risc_defs):
//   - opcode constants (ADD 4'b0000, NAND 4'b0010, SW 4'b1001, LW 4'b1010, BEQ 4'b1011, JAL 4'b1101)
//   - NOP_INSTR
//   - fetch-state encoding (FS_IDLE, FS_FETCH)
//   - control FSM state codes, moved there from the control unit
//  One sub-module: pc_target_gen (combinational sign-extend and add; also used by the datapath).
//  Wait counter width is clog2(MAX_WAIT)+1.
// TESTING
//  1. Reset, pc_write pulse, memory acks in the first req cycle with 16'h1234:
//     imem_addr=0000, instruction=1234, pc_cur=0000, pc=0001, ir_valid=1 two edges after pc_write.
//  2. Memory with 3 wait states:
//     imem_req high for 4 cycles, imem_addr stable, IR updates only on the ack cycle.
//  3. pc_cur=0010, IR=16'hB03E (BEQ, offset -2), branch=1, Zero=1, then pc_write:
//     fetch address 000E. Repeat with Zero=0: fetch address 0011.
//  4. pc_cur=FFFF, jump=1, offset +1:
//     target 0000. Also, a sequential fetch at FFFF gives pc=0000.
//  5. No ack for MAX_WAIT cycles:
//     imem_req drops, instruction=F000, fetch_err=1 (sticky), pc unchanged; the next pc_write refetches the same address.
//  6. proc_rst asserted in the 2nd FETCH cycle, ack on the following cycle:
//     outputs at reset values, IR not updated, imem_req=0.

Source files
------------

// File: rtl/risc_defs_pkg.sv
// risc_defs: opcodes, NOP word and state encodings shared by the RISC core blocks.
package risc_defs;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_JAL  = 4'b1101;
    // Opcode 4'hF has no decode path in control, so this word executes as a no-op.
    localparam logic [15:0] NOP_INSTR = 16'hF000;
    typedef enum logic {FS_IDLE, FS_FETCH} fetch_state_e;
    typedef enum logic [2:0] {CS_IF, CS_ID, CS_EX, CS_MEM, CS_WB} ctrl_state_e;
endpackage

// File: rtl/pc_target_gen.sv
// pc_target_gen: sign-extends an OFF_W-bit offset and adds it to a 16-bit base, wrapping modulo 2^16.
module pc_target_gen #(
    parameter int OFF_W = 6
) (
    input  logic [15:0]      base_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [15:0]      target_o
);
    assign target_o = base_i + {{(16-OFF_W){off_i[OFF_W-1]}}, off_i};
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC and IR, fetches over a req/ack handshake with a wait-state timeout,
// and applies branch/jump redirects relative to the PC of the instruction in the IR.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = risc_defs::NOP_INSTR,
    parameter int          MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        proc_rst,
    input  logic        pc_write,
    input  logic        branch,
    input  logic        jump,
    input  logic        Zero,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] instruction,
    output logic [3:0]  opcode,
    output logic        ir_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_cur,
    output logic        fetch_err
);
    import risc_defs::*;
    localparam int WW = $clog2(MAX_WAIT) + 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);
    fetch_state_e  state_q;
    logic [15:0]   pc_q, pc_cur_q, ir_q, addr_q;
    logic          ir_valid_q, req_q, err_q;
    logic [WW-1:0] wait_q;
    logic [15:0]   br_tgt, jmp_tgt, target, fetch_addr;
    logic          taken;
    pc_target_gen #(.OFF_W(6)) u_br_tgt (.base_i(pc_cur_q), .off_i(ir_q[5:0]), .target_o(br_tgt));
    pc_target_gen #(.OFF_W(9)) u_jmp_tgt (.base_i(pc_cur_q), .off_i(ir_q[8:0]), .target_o(jmp_tgt));
    always_comb begin
        taken      = jump | (branch & Zero);
        target     = jump ? jmp_tgt : br_tgt;
        fetch_addr = taken ? target : pc_q;
    end
    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            pc_cur_q   <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= '0;
        end else if (state_q == FS_IDLE) begin
            addr_q <= fetch_addr;
            if (taken) pc_q <= target;
            if (pc_write) begin
                ir_valid_q <= 1'b0;
                req_q      <= 1'b1;
                wait_q     <= '0;
                state_q    <= FS_FETCH;
            end
        end else if (imem_ack) begin
            ir_q       <= imem_rdata;
            pc_cur_q   <= addr_q;
            pc_q       <= addr_q + 16'd1;
            addr_q     <= addr_q + 16'd1;
            ir_valid_q <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= FS_IDLE;
        end else if (wait_q == LAST_WAIT) begin
            // Timeout leaves pc alone so the next fetch retries the same address.
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b1;
            err_q      <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= FS_IDLE;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = ir_q;
    assign opcode      = ir_q[15:12];
    assign ir_valid    = ir_valid_q;
    assign pc          = pc_q;
    assign pc_cur      = pc_cur_q;
    assign fetch_err   = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of reset, fetch latency, wait states, redirects, wrap, timeout and mid-fetch reset.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        proc_rst, pc_write, branch, jump, Zero, imem_ack;
    logic [15:0] imem_rdata;
    logic        imem_req, ir_valid, fetch_err;
    logic [15:0] imem_addr, instruction, pc, pc_cur;
    logic [3:0]  opcode;
    int          n_chk = 0;
    int          errs  = 0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'hF000), .MAX_WAIT(8)) dut (
        .clk(clk), .proc_rst(proc_rst), .pc_write(pc_write), .branch(branch), .jump(jump),
        .Zero(Zero), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .instruction(instruction), .opcode(opcode), .ir_valid(ir_valid),
        .pc(pc), .pc_cur(pc_cur), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [15:0] a, input int waits, input logic [15:0] d, input logic [15:0] old_ir);
        logic [15:0] nx;
        nx = a + 16'd1;
        pc_write = 1'b1;
        step;
        pc_write = 1'b0;
        branch = 1'b0;
        jump = 1'b0;
        Zero = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk("req_wait", imem_req, 1);
            chk("addr_hold", imem_addr, a);
            chk("ir_hold", instruction, old_ir);
            chk("irv_low", ir_valid, 0);
            step;
        end
        chk("req_ack", imem_req, 1);
        chk("addr", imem_addr, a);
        imem_ack = 1'b1;
        imem_rdata = d;
        step;
        imem_ack = 1'b0;
        chk("req_drop", imem_req, 0);
        chk("ir", instruction, d);
        chk("irv", ir_valid, 1);
        chk("pc_cur", pc_cur, a);
        chk("pc", pc, nx);
    endtask

    initial begin
        proc_rst = 1'b1; pc_write = 1'b0; branch = 1'b0; jump = 1'b0; Zero = 1'b0;
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        step;
        step;
        proc_rst = 1'b0;
        chk("rst_ir", instruction, 16'hF000);
        chk("rst_op", opcode, 4'hF);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_pc_cur", pc_cur, 16'h0000);
        chk("rst_irv", ir_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_addr", imem_addr, 16'h0000);
        // zero-wait fetch, IR valid two edges after pc_write
        fetch(16'h0000, 0, 16'h1234, 16'hF000);
        chk("opcode", opcode, 4'h1);
        // three wait states: req high four cycles
        fetch(16'h0001, 3, 16'hD00F, 16'h1234);
        // jump +15 from pc_cur 0001
        jump = 1'b1;
        fetch(16'h0010, 0, 16'hB03E, 16'hD00F);
        // branch not taken leaves pc at 0011
        branch = 1'b1; Zero = 1'b0;
        step;
        chk("br_nt_pc", pc, 16'h0011);
        chk("br_nt_addr", imem_addr, 16'h0011);
        // taken branch -2 together with pc_write
        Zero = 1'b1;
        fetch(16'h000E, 0, 16'hD1F1, 16'hB03E);
        // jump -15 from 000E lands on FFFF, sequential pc wraps to 0000
        jump = 1'b1;
        fetch(16'hFFFF, 0, 16'hD001, 16'hD1F1);
        chk("wrap_addr", imem_addr, 16'h0000);
        // jump +1 from FFFF wraps to 0000
        jump = 1'b1;
        fetch(16'h0000, 0, 16'h5A5A, 16'hD001);
        // timeout after MAX_WAIT cycles without ack
        pc_write = 1'b1;
        step;
        pc_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_req", imem_req, 1);
            chk("to_addr", imem_addr, 16'h0001);
            step;
        end
        chk("to_req_drop", imem_req, 0);
        chk("to_ir", instruction, 16'hF000);
        chk("to_err", fetch_err, 1);
        chk("to_irv", ir_valid, 1);
        chk("to_pc", pc, 16'h0001);
        chk("to_pc_cur", pc_cur, 16'h0000);
        fetch(16'h0001, 0, 16'h2222, 16'hF000);
        chk("err_sticky", fetch_err, 1);
        // reset during 2nd FETCH cycle, ack arrives afterwards
        pc_write = 1'b1;
        step;
        pc_write = 1'b0;
        step;
        proc_rst = 1'b1;
        step;
        proc_rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        step;
        imem_ack = 1'b0;
        chk("mr_req", imem_req, 0);
        chk("mr_ir", instruction, 16'hF000);
        chk("mr_irv", ir_valid, 0);
        chk("mr_pc", pc, 16'h0000);
        chk("mr_pc_cur", pc_cur, 16'h0000);
        chk("mr_err", fetch_err, 0);
        chk("mr_addr", imem_addr, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, errs);
        $finish;
    end
endmodule
